pspin_stdout_packer: RTL

Producer side of the PsPIN stdout FIFO, whose consumer is the host-visible control register read port at 0x1000. The block collects byte-wide printf output from NUM_SRC core sources, packs up to three characters per source into one tagged 32-bit word, and writes words into the stdout FIFO under round-robin arbitration. Host software unpacks each word by source id and character count.

---
 rtl/pspin_stdout_packer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pspin_stdout_packer.sv
// pspin_stdout_packer
// Producer side of the PsPIN stdout FIFO. It collects byte-wide printf output
// from NUM_SRC core sources and packs up to three characters per source into
// one tagged 32-bit word. Sealed words are written into the stdout FIFO under
// round-robin arbitration.
//
// Word format: [31:30] character count (1..3), [29:24] source index,
//              [23:0] characters, first character in [7:0], unused lanes 0.
//
// Ports:
//   clk           sole clock
//   rst_n         asynchronous active-low reset
//   src_valid     per-source byte valid
//   src_data      per-source byte, source i on [8*i +: 8]
//   src_ready     per-source ready (low while that source holds a sealed word)
//   stdout_din    FIFO write data (registered)
//   stdout_wr_en  FIFO write strobe (registered, one write per high cycle)
//   stdout_full   FIFO programmable-full (must leave at least one free entry)
//
// Build option: define PSPIN_STDOUT_TIMEOUT_EN to add per-source idle counters
// that seal a partial word after FLUSH_TIMEOUT idle cycles. Without it a
// partial word is sealed only by a newline or by its third character.
module pspin_stdout_packer #(
   parameter int unsigned NUM_SRC       = 16,
   parameter int unsigned FLUSH_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_SRC-1:0]   src_valid,
   input  logic [NUM_SRC*8-1:0] src_data,
   output logic [NUM_SRC-1:0]   src_ready,
   output logic [31:0]          stdout_din,
   output logic                 stdout_wr_en,
   input  logic                 stdout_full
);

   localparam int unsigned IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int unsigned PTR_W   = IDX_W + 1;
   localparam logic [7:0]  NEWLINE = 8'h0A;

   // Elaboration-time parameter range checks
   if (NUM_SRC < 1 || NUM_SRC > 64) begin : g_bad_num_src
      $error("pspin_stdout_packer: NUM_SRC must be within 1..64");
   end
   if (FLUSH_TIMEOUT < 2) begin : g_bad_flush_timeout
      $error("pspin_stdout_packer: FLUSH_TIMEOUT must be at least 2");
   end

   logic [NUM_SRC-1:0]        sealed;
   logic [NUM_SRC-1:0][23:0]  acc;
   logic [NUM_SRC-1:0][1:0]   cnt;

   logic [IDX_W-1:0]          rr_ptr;
   logic [IDX_W-1:0]          rr_next;
   logic [IDX_W-1:0]          gnt_idx;
   logic                      gnt_any;
   logic                      gnt_valid;
   logic [PTR_W-1:0]          scan;

   // Sealed sources stall; nothing is ready while reset is held
   assign src_ready = ~sealed & {NUM_SRC{rst_n}};

   // Round-robin pick: lowest sealed index at or after rr_ptr, wrapping
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = '0;
      for (int unsigned off = 0; off < NUM_SRC; off++) begin
         scan = PTR_W'(rr_ptr) + PTR_W'(off);
         if (scan >= PTR_W'(NUM_SRC)) begin
            scan = scan - PTR_W'(NUM_SRC);
         end
         if (!gnt_any && sealed[IDX_W'(scan)]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(scan);
         end
      end
   end

   // A full FIFO blocks the grant; sealed words simply wait
   assign gnt_valid = gnt_any & ~stdout_full;
   assign rr_next   = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);

   // Per-source packing state
   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      logic [7:0]  data_in;
      logic        accept;
      logic        granted;
      logic        idle_hit;
      logic [23:0] acc_r;
      logic [1:0]  cnt_r;
      logic        sealed_r;

      assign data_in = src_data[8*g +: 8];
      assign accept  = src_valid[g] & ~sealed_r;
      assign granted = gnt_valid & (gnt_idx == IDX_W'(g));

`ifdef PSPIN_STDOUT_TIMEOUT_EN
      localparam int unsigned IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
      logic [IDLE_W-1:0] idle_r;

      // Timeout fires on the cycle the counter would reach FLUSH_TIMEOUT;
      // an accepted byte in that cycle takes priority in the register below.
      assign idle_hit = ~sealed_r && (cnt_r != 2'd0) &&
                        (idle_r == IDLE_W'(FLUSH_TIMEOUT - 1));

      // Idle counter: cleared by traffic or grant, counts while a partial word waits
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            idle_r <= '0;
         end else if (granted || accept) begin
            idle_r <= '0;
         end else if (!sealed_r && cnt_r != 2'd0) begin
            idle_r <= idle_r + IDLE_W'(1);
         end
      end
`else
      assign idle_hit = 1'b0;
`endif

      // Accumulator, character count and sealed flag
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            acc_r    <= '0;
            cnt_r    <= '0;
            sealed_r <= 1'b0;
         end else if (granted) begin
            acc_r    <= '0;
            cnt_r    <= '0;
            sealed_r <= 1'b0;
         end else if (accept) begin
            case (cnt_r)
               2'd0:    acc_r[7:0]   <= data_in;
               2'd1:    acc_r[15:8]  <= data_in;
               default: acc_r[23:16] <= data_in;
            endcase
            cnt_r    <= cnt_r + 2'd1;
            // Third character or newline closes the word (newline included)
            sealed_r <= (cnt_r == 2'd2) || (data_in == NEWLINE);
         end else if (idle_hit) begin
            sealed_r <= 1'b1;
         end
      end

      assign acc[g]    = acc_r;
      assign cnt[g]    = cnt_r;
      assign sealed[g] = sealed_r;
   end

   // FIFO write port and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stdout_wr_en <= 1'b0;
         stdout_din   <= '0;
         rr_ptr       <= '0;
      end else begin
         stdout_wr_en <= gnt_valid;
         if (gnt_valid) begin
            stdout_din <= {cnt[gnt_idx], 6'(gnt_idx), acc[gnt_idx]};
            rr_ptr     <= rr_next;
         end
      end
   end

endmodule
